// File: rtl/buffer_ctrl_pkg.sv
// Shared types and helpers for the circular-buffer access controller.
// Imported by the arbiter and the controller top.
package buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } ctrl_state_t;

    // Index width for a buffer of the given depth; never narrower than one bit.
    function automatic int sel_width(input int size);
        if (size > 1) begin
            return $clog2(size);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
// The grant is combinational from the requests; the history flop moves only on an accepted beat.
module rr_arbiter2
    import buffer_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    // Tie goes to the requester that was not granted last.
    always_comb begin
        w_grant = 2'b00;
        case (req)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    // Resets to 1 so wr0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (accept) begin
            r_last_grant <= w_grant[1];
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign grant = w_grant;

endmodule

// File: rtl/buffer_access_ctrl.sv
// Access controller in front of the parallel-port circular buffer: write arbitration,
// read handshake, full/empty gating and the drain-then-clear flush sequence.
module buffer_access_ctrl
    import buffer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 16,
    parameter int PAR_WRITE  = 1,
    parameter int PAR_READ   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr0_valid,
    input  logic [DATA_WIDTH*PAR_WRITE-1:0] wr0_data,
    output logic                            wr0_ready,
    input  logic                            wr1_valid,
    input  logic [DATA_WIDTH*PAR_WRITE-1:0] wr1_data,
    output logic                            wr1_ready,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    input  logic                            flush,
    output logic                            flush_done,
    output logic                            busy,
    input  logic                            full,
    input  logic                            empty,
    output logic                            write_enable,
    output logic                            read_enable,
    output logic [DATA_WIDTH*PAR_WRITE-1:0] data_in,
    output logic                            buf_clear
);

    localparam int SEL_WIDTH = sel_width(SIZE);

    if (((32'd1 << SEL_WIDTH) != 32'(SIZE)) || (PAR_READ > SIZE) || (PAR_WRITE > SIZE)) begin : g_param_check
        $error("buffer_access_ctrl: SIZE must be a power of two no smaller than PAR_READ/PAR_WRITE");
    end

    ctrl_state_t r_state;
    logic        r_buf_clear;
    logic        r_flush_done;

    logic [1:0]  w_grant;
    logic        w_wr0_ready;
    logic        w_wr1_ready;
    logic        w_rd_valid;
    logic        w_write_enable;
    logic        w_read_enable;
    logic [DATA_WIDTH*PAR_WRITE-1:0] w_data_in;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({wr1_valid, wr0_valid}),
        .accept (w_write_enable),
        .grant  (w_grant)
    );

    // Handshake gating: writes only in RUN, reads in RUN and DRAIN, nothing in CLEAR.
    always_comb begin
        w_wr0_ready = 1'b0;
        w_wr1_ready = 1'b0;
        w_rd_valid  = 1'b0;
        case (r_state)
            RUN: begin
                w_wr0_ready = w_grant[0] & ~full;
                w_wr1_ready = w_grant[1] & ~full;
                w_rd_valid  = ~empty;
            end
            DRAIN: begin
                w_rd_valid  = ~empty;
            end
            CLEAR: begin
                w_rd_valid  = 1'b0;
            end
            default: begin
                w_rd_valid  = 1'b0;
            end
        endcase
        w_write_enable = w_wr0_ready | w_wr1_ready;
        w_read_enable  = w_rd_valid & rd_ready;
    end

    // Beat mux; falls back to wr0 when nobody is granted.
    always_comb begin
        if (w_grant[1]) begin
            w_data_in = wr1_data;
        end else begin
            w_data_in = wr0_data;
        end
    end

    // Flush sequencer; buf_clear and flush_done come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_buf_clear  <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_buf_clear  <= 1'b0;
            r_flush_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (flush) begin
                        r_state <= DRAIN;
                    end else begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        r_state     <= CLEAR;
                        r_buf_clear <= 1'b1;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                CLEAR: begin
                    r_state      <= RUN;
                    r_flush_done <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign wr0_ready    = w_wr0_ready;
    assign wr1_ready    = w_wr1_ready;
    assign rd_valid     = w_rd_valid;
    assign write_enable = w_write_enable;
    assign read_enable  = w_read_enable;
    assign data_in      = w_data_in;
    assign buf_clear    = r_buf_clear;
    assign flush_done   = r_flush_done;
    assign busy         = (r_state != RUN);

endmodule

// File: tb/tb_buffer_access_ctrl.sv
// Self-checking bench for buffer_access_ctrl with a behavioural buffer model and a data scoreboard.
module tb_buffer_access_ctrl;
    import buffer_ctrl_pkg::*;

    localparam int DW = 8;
    localparam int SZ = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr0_valid, wr1_valid, rd_ready, flush, full, empty;
    logic [DW-1:0] wr0_data, wr1_data, data_in;
    logic          wr0_ready, wr1_ready, rd_valid, flush_done, busy;
    logic          write_enable, read_enable, buf_clear;

    buffer_access_ctrl #(.DATA_WIDTH(DW), .SIZE(SZ), .PAR_WRITE(1), .PAR_READ(1)) dut (
        .clk(clk), .rst(rst),
        .wr0_valid(wr0_valid), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
        .wr1_valid(wr1_valid), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .flush(flush), .flush_done(flush_done), .busy(busy),
        .full(full), .empty(empty),
        .write_enable(write_enable), .read_enable(read_enable),
        .data_in(data_in), .buf_clear(buf_clear)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb_q[$];
    ctrl_state_t   m_st;
    logic          m_last, m_fd;
    int            n_clear, n_done;
    logic          done_empty;
    logic          l_r0, l_r1, l_we, l_re, l_busy, l_bclr, l_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: check settled outputs, clock, then update buffer model and reference state.
    task automatic step();
        logic g0, g1, e_r0, e_r1, e_we, e_rv, e_re;
        logic [DW-1:0] e_din, s_din;
        logic s_we, s_re, s_clr, s_rst;
        #1;
        g0    = wr0_valid & (~wr1_valid | m_last);
        g1    = wr1_valid & (~wr0_valid | ~m_last);
        e_r0  = (m_st == RUN) & g0 & ~full;
        e_r1  = (m_st == RUN) & g1 & ~full;
        e_we  = e_r0 | e_r1;
        e_rv  = (m_st != CLEAR) & ~empty;
        e_re  = e_rv & rd_ready;
        e_din = g1 ? wr1_data : wr0_data;
        if (!rst) begin
            check("wr0_ready", wr0_ready, e_r0);
            check("wr1_ready", wr1_ready, e_r1);
            check("write_enable", write_enable, e_we);
            check("rd_valid", rd_valid, e_rv);
            check("read_enable", read_enable, e_re);
            check("data_in", data_in, e_din);
            check("busy", busy, m_st != RUN);
            check("buf_clear", buf_clear, m_st == CLEAR);
            check("flush_done", flush_done, m_fd);
            if (m_st == CLEAR) check("sb_empty_at_clear", sb_q.size(), 0);
            if (e_re) begin
                check("sb_has_word", (sb_q.size() != 0 && fifo_q.size() != 0), 1'b1);
                if (sb_q.size() != 0 && fifo_q.size() != 0) begin
                    check("rd_data_order", fifo_q[0], sb_q.pop_front());
                end
            end
        end
        if (buf_clear) n_clear++;
        if (flush_done) begin
            n_done++;
            done_empty = empty;
        end
        l_r0 = wr0_ready; l_r1 = wr1_ready; l_we = write_enable; l_re = read_enable;
        l_busy = busy; l_bclr = buf_clear; l_fd = flush_done;
        s_we = write_enable; s_re = read_enable; s_din = data_in; s_clr = buf_clear; s_rst = rst;
        @(posedge clk);
        #1;
        if (s_rst || s_clr) begin
            fifo_q.delete();
        end else begin
            if (s_re && fifo_q.size() != 0) void'(fifo_q.pop_front());
            if (s_we && fifo_q.size() < SZ) fifo_q.push_back(s_din);
        end
        if (s_rst) begin
            sb_q.delete();
            m_st = RUN; m_last = 1'b1; m_fd = 1'b0;
        end else begin
            if (e_we) sb_q.push_back(e_din);
            if (m_st == CLEAR) sb_q.delete();
            m_fd = (m_st == CLEAR);
            if (e_we) m_last = g1;
            case (m_st)
                RUN:     if (flush) m_st = DRAIN;
                DRAIN:   if (empty) m_st = CLEAR;
                CLEAR:   m_st = RUN;
                default: m_st = RUN;
            endcase
        end
        full  = (fifo_q.size() == SZ);
        empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic drive(input logic v0, input logic v1, input logic rr, input logic fl);
        wr0_valid = v0; wr1_valid = v1; rd_ready = rr; flush = fl;
        wr0_data  = DW'($urandom);
        wr1_data  = DW'($urandom);
        step();
    endtask

    initial begin
        rst = 1'b1; wr0_valid = 1'b0; wr1_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
        wr0_data = '0; wr1_data = '0; full = 1'b0; empty = 1'b1;
        m_st = RUN; m_last = 1'b1; m_fd = 1'b0; n_clear = 0; n_done = 0; done_empty = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_buf_clear", buf_clear, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        @(negedge clk);

        // Tie: alternation wr0, wr1, wr0, wr1.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            check("tie_wr0", l_r0, (i % 2) == 0);
            check("tie_wr1", l_r1, (i % 2) == 1);
        end

        // Fill to full, then backpressure.
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("full_flag", full, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            check("full_no_ready", l_r0, 1'b0);
            check("full_no_we", l_we, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("free_read", l_re, 1'b1);
        check("free_still_blocked", l_we, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("free_write_next", l_we, 1'b1);

        // Read handshake with toggling rd_ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, (i % 2) == 0, 1'b0);
            check("rd_toggle", l_re, (i % 2) == 0);
        end
        check("level_after_reads", fifo_q.size(), 12);

        // Simultaneous read and write.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            check("simul_both", l_we & l_re, 1'b1);
        end
        check("simul_level", fifo_q.size(), 12);

        // Drain out, load 8, flush with data.
        for (int i = 0; i < 20; i++) if (!empty) drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("drained", empty, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("loaded8", fifo_q.size(), 8);
        n_clear = 0; n_done = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        check("flush_cycle_write", l_we, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (n_done == 0) begin
                drive(1'b1, 1'b0, 1'b1, 1'b0);
                if (l_busy) check("drain_no_ready", l_r0, 1'b0);
            end
        end
        check("flush_clear_once", n_clear, 1);
        check("flush_done_once", n_done, 1);
        check("empty_at_done", done_empty, 1'b1);

        // Flush on an empty buffer: DRAIN, CLEAR, then done.
        for (int i = 0; i < 20; i++) if (!empty) drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_busy", l_busy, 1'b1);
        check("t1_no_clear", l_bclr, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_clear", l_bclr, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_done", l_fd, 1'b1);
        check("t3_idle", l_busy, 1'b0);

        // Reset in a stalled drain; repeated flush is ignored.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_busy", l_busy, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_busy", l_busy, 1'b0);
        check("post_rst_done", l_fd, 1'b0);
        check("post_rst_clear", l_bclr, 1'b0);
        check("post_rst_wr0_wins", l_r0, 1'b1);
        check("post_rst_wr1_waits", l_r1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_alt", l_r1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
